ppi_bus_controller: RTL and testbench

Sequencing controller for the PPI 8255A CPU-side data bus buffer. It synchronizes the asynchronous CPU strobes (cs_n, rd_n, wr_n) to the system clock and decodes A1:A0. It drives the buffer enable and the read data, and captures write data into port or control-word write strobes. It sits between the external CPU pins and the DataBusBuffer / port-group logic; the buffer itself stays purely combinational.

---
 rtl/ppi_bus_controller.sv | 168 ++++++++++++++++
 tb/tb_ppi_bus_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_controller.sv
// PPI 8255A CPU-side bus sequencer: strobe synchronizers, read mux,
// write capture and control-word register.
module ppi_bus_controller #(
  parameter logic [7:0] CTRL_RESET = 8'h9B
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] d_in,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic       buf_oe,
  output logic [7:0] d_out,
  output logic       wr_stb,
  output logic [1:0] wr_sel,
  output logic [7:0] wr_data,
  output logic [7:0] ctrl_word,
  output logic       mode_stb,
  output logic       bsr_stb
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, WAIT_REL
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] cs_q, rd_q, wr_q;
  logic [1:0] fill;
  logic       armed;
  logic       cs_act, rd_act, wr_act;
  logic       commit;

  logic       buf_oe_d;
  logic [7:0] d_out_d, rd_mux;
  logic       wr_stb_d, mode_stb_d, bsr_stb_d;
  logic [1:0] wr_sel_d;
  logic [7:0] wr_data_d, ctrl_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q <= 2'b11;
      rd_q <= 2'b11;
      wr_q <= 2'b11;
    end else begin
      cs_q <= {cs_q[0], cs_n};
      rd_q <= {rd_q[0], rd_n};
      wr_q <= {wr_q[0], wr_n};
    end
  end

  assign cs_act = ~cs_q[1];
  assign rd_act = ~rd_q[1];
  assign wr_act = ~wr_q[1];

  // Until the synchronizers hold post-reset pin samples, a strobe
  // already low on the pins must not start a transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (!fill[1])
        fill <= fill + 2'd1;
      if (fill[1] && state_nxt == IDLE)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!armed) begin
          if (fill[1] && (rd_act || wr_act))
            state_nxt = WAIT_REL;
        end else if (cs_act && rd_act && wr_act)
          state_nxt = WAIT_REL;
        else if (cs_act && rd_act)
          state_nxt = READ;
        else if (cs_act && wr_act)
          state_nxt = WRITE;
      end
      READ: begin
        if (!rd_act || !cs_act)
          state_nxt = IDLE;
      end
      WRITE: begin
        if (rd_act)
          state_nxt = WAIT_REL;
        else if (!cs_act)
          state_nxt = IDLE;
        else if (!wr_act) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!rd_act && !wr_act && !cs_act)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = ctrl_word;
    unique case (1'b1)
      (a == 2'd0): rd_mux = pa_in;
      (a == 2'd1): rd_mux = pb_in;
      (a == 2'd2): rd_mux = pc_in;
      default:     rd_mux = ctrl_word;
    endcase
  end

  // Strobe decode uses the captured sample, not the live pins,
  // since the CPU may already be changing a/d_in.
  always_comb begin
    buf_oe_d   = (state_nxt == READ);
    d_out_d    = d_out;
    wr_sel_d   = wr_sel;
    wr_data_d  = wr_data;
    if (state_nxt == READ)
      d_out_d = rd_mux;
    if (state_nxt == WRITE) begin
      wr_sel_d  = a;
      wr_data_d = d_in;
    end
    wr_stb_d   = commit && (wr_sel != 2'd3);
    mode_stb_d = commit && (wr_sel == 2'd3) && wr_data[7];
    bsr_stb_d  = commit && (wr_sel == 2'd3) && !wr_data[7];
    ctrl_d     = mode_stb_d ? wr_data : ctrl_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_oe    <= 1'b0;
      d_out     <= 8'h00;
      wr_stb    <= 1'b0;
      wr_sel    <= 2'd0;
      wr_data   <= 8'h00;
      ctrl_word <= CTRL_RESET;
      mode_stb  <= 1'b0;
      bsr_stb   <= 1'b0;
    end else begin
      buf_oe    <= buf_oe_d;
      d_out     <= d_out_d;
      wr_stb    <= wr_stb_d;
      wr_sel    <= wr_sel_d;
      wr_data   <= wr_data_d;
      ctrl_word <= ctrl_d;
      mode_stb  <= mode_stb_d;
      bsr_stb   <= bsr_stb_d;
    end
  end

endmodule

// File: tb/tb_ppi_bus_controller.sv
// Directed bench for ppi_bus_controller: reads, writes, control
// words, abort, rd/wr conflict and reset mid-transaction.
module tb_ppi_bus_controller;

  logic       clk;
  logic       reset_n;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] a;
  logic [7:0] d_in, pa_in, pb_in, pc_in;
  logic       buf_oe;
  logic [7:0] d_out;
  logic       wr_stb;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [7:0] ctrl_word;
  logic       mode_stb;
  logic       bsr_stb;

  int n_run;
  int n_fail;
  int n_wr, n_mode, n_bsr;

  ppi_bus_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a         (a),
    .d_in      (d_in),
    .pa_in     (pa_in),
    .pb_in     (pb_in),
    .pc_in     (pc_in),
    .buf_oe    (buf_oe),
    .d_out     (d_out),
    .wr_stb    (wr_stb),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .ctrl_word (ctrl_word),
    .mode_stb  (mode_stb),
    .bsr_stb   (bsr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb)   n_wr   <= n_wr + 1;
    if (mode_stb) n_mode <= n_mode + 1;
    if (bsr_stb)  n_bsr  <= n_bsr + 1;
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stb_chk(input string tag, input logic [2:0] exp);
    chk(tag, {5'd0, wr_stb, mode_stb, bsr_stb}, {5'd0, exp});
  endtask

  task automatic wr_cycle(input logic [1:0] aa,
                          input logic [7:0] dd,
                          input logic [2:0] e_stb);
    a    = aa;
    d_in = dd;
    cs_n = 1'b0;
    wr_n = 1'b0;
    repeat (5) tick();
    wr_n = 1'b1;
    repeat (2) tick();
    stb_chk("stb_early", 3'b000);
    tick();
    stb_chk("stb_fire", e_stb);
    chk("wr_sel", {6'd0, wr_sel}, {6'd0, aa});
    chk("wr_data", wr_data, dd);
    tick();
    stb_chk("stb_width", 3'b000);
    cs_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    n_wr   = 0;
    n_mode = 0;
    n_bsr  = 0;
    reset_n = 1'b0;
    cs_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    a     = 2'd0;
    d_in  = 8'h00;
    pa_in = 8'h11;
    pb_in = 8'h5A;
    pc_in = 8'h33;
    repeat (3) tick();
    chk("rst_ctrl", ctrl_word, 8'h9B);
    chk("rst_oe", {7'd0, buf_oe}, 8'd0);
    stb_chk("rst_stb", 3'b000);
    chk("rst_dout", d_out, 8'h00);

    // release reset with a read already on the pins
    a    = 2'd1;
    cs_n = 1'b0;
    rd_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("rel_rd_oe", {7'd0, buf_oe}, 8'd0);
    cs_n = 1'b1;
    rd_n = 1'b1;
    repeat (4) tick();

    cs_n = 1'b0;
    rd_n = 1'b0;
    repeat (2) tick();
    chk("pb_oe_e2", {7'd0, buf_oe}, 8'd0);
    tick();
    chk("pb_oe_e3", {7'd0, buf_oe}, 8'd1);
    chk("pb_dout", d_out, 8'h5A);
    repeat (2) tick();
    pb_in = 8'hA5;
    tick();
    chk("pb_track", d_out, 8'hA5);
    rd_n = 1'b1;
    cs_n = 1'b1;
    repeat (2) tick();
    chk("pb_off_e2", {7'd0, buf_oe}, 8'd1);
    tick();
    chk("pb_off_e3", {7'd0, buf_oe}, 8'd0);
    repeat (3) tick();

    wr_cycle(2'd0, 8'hC3, 3'b100);
    wr_cycle(2'd3, 8'h80, 3'b010);
    chk("ctrl_mode", ctrl_word, 8'h80);
    wr_cycle(2'd3, 8'h07, 3'b001);
    chk("ctrl_bsr", ctrl_word, 8'h80);

    a    = 2'd3;
    cs_n = 1'b0;
    rd_n = 1'b0;
    repeat (4) tick();
    chk("rd_ctrl_oe", {7'd0, buf_oe}, 8'd1);
    chk("rd_ctrl", d_out, 8'h80);
    cs_n = 1'b1;
    rd_n = 1'b1;
    repeat (5) tick();

    // cs_n leaves before wr_n: no strobe
    a    = 2'd1;
    d_in = 8'h77;
    cs_n = 1'b0;
    wr_n = 1'b0;
    repeat (5) tick();
    cs_n = 1'b1;
    repeat (2) tick();
    wr_n = 1'b1;
    repeat (5) tick();
    chk("abort_wr", n_wr[7:0], 8'd1);
    chk("abort_mode", n_mode[7:0], 8'd1);
    chk("abort_bsr", n_bsr[7:0], 8'd1);

    // rd and wr both low
    a    = 2'd0;
    cs_n = 1'b0;
    rd_n = 1'b0;
    wr_n = 1'b0;
    repeat (6) tick();
    chk("cfl_oe", {7'd0, buf_oe}, 8'd0);
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (5) tick();
    rd_n = 1'b0;
    repeat (5) tick();
    chk("cfl_hold_cs", {7'd0, buf_oe}, 8'd0);
    cs_n = 1'b1;
    rd_n = 1'b1;
    repeat (4) tick();
    cs_n = 1'b0;
    rd_n = 1'b0;
    repeat (3) tick();
    chk("cfl_recover", {7'd0, buf_oe}, 8'd1);
    chk("cfl_dout", d_out, 8'h11);
    chk("cfl_stb", n_wr[7:0], 8'd1);

    // asynchronous reset in the middle of that read
    reset_n = 1'b0;
    #1;
    chk("arst_oe", {7'd0, buf_oe}, 8'd0);
    chk("arst_ctrl", ctrl_word, 8'h9B);
    chk("arst_wdata", wr_data, 8'h00);
    chk("arst_wsel", {6'd0, wr_sel}, 8'd0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("arst_rel_oe", {7'd0, buf_oe}, 8'd0);
    cs_n = 1'b1;
    rd_n = 1'b1;
    repeat (5) tick();

    a    = 2'd3;
    cs_n = 1'b0;
    rd_n = 1'b0;
    repeat (3) tick();
    chk("post_rst_rd", d_out, 8'h9B);
    cs_n = 1'b1;
    rd_n = 1'b1;
    repeat (5) tick();

    chk("tot_wr", n_wr[7:0], 8'd1);
    chk("tot_mode", n_mode[7:0], 8'd1);
    chk("tot_bsr", n_bsr[7:0], 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
